// File: rtl/ristretto_imem_fetch_ctrl.sv
// Ristretto IF-stage fetch controller: drives the imem req/rdy/rvalid handshake,
// owns the PC, and meters pushes into the prefetch buffer with a credit counter.
module ristretto_imem_fetch_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rdy_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        pf_push_o,
    output logic [31:0] pf_data_o,
    output logic [31:0] pf_addr_o,
    input  logic        pf_pop_i,
    output logic        pf_flush_o,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WRDY = 2'b01;
    localparam logic [1:0] S_WVLD = 2'b10;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

    if (!(DEPTH == 4 || DEPTH == 8 || DEPTH == 16 || DEPTH == 32)) begin : g_depth_chk
        $error("ristretto_imem_fetch_ctrl: DEPTH must be 4, 8, 16 or 32");
    end

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          kill_q, kill_d;
    logic          push_q, push_d;
    logic [31:0]   pdata_q, pdata_d;
    logic [31:0]   paddr_q, paddr_d;
    logic          flush_q, flush_d;

    logic        issue, rsp, accept, take, pop_ok;
    logic [31:0] pc_adv;

    always_comb begin
        issue   = fetch_en_i && (cred_q != '0) && !redirect_i;
        rsp     = (state_q == S_WVLD) && imem_rvalid_i;
        accept  = rsp && !kill_q && !redirect_i;
        pc_adv  = accept ? pc_q + 32'd4 : pc_q;
        take    = 1'b0;
        state_d = state_q;

        case (state_q)
            S_IDLE: if (issue) begin
                state_d = S_WRDY;
                take    = 1'b1;
            end
            S_WRDY: if (imem_rdy_i) state_d = S_WVLD;
            S_WVLD: if (imem_rvalid_i) begin
                state_d = issue ? S_WRDY : S_IDLE;
                take    = issue;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush refills every credit, so a same-cycle pop has nothing left to return.
        pop_ok = pf_pop_i && !redirect_i && (cred_q != CRED_MAX);
        cred_d = redirect_i ? CRED_MAX : cred_q + CW'(pop_ok) - CW'(take);

        pc_d   = redirect_i ? (redirect_addr_i & 32'hFFFF_FFFC) : pc_adv;
        // The request address is latched at issue so a redirect cannot move a pending request.
        addr_d = take ? pc_adv : addr_q;

        // A redirect that coincides with the response has nothing left in flight to kill.
        kill_d = kill_q;
        if (state_q != S_WRDY && state_q != S_WVLD)
            kill_d = 1'b0;
        else if (redirect_i && (state_q == S_WRDY || !imem_rvalid_i))
            kill_d = 1'b1;
        else if (rsp)
            kill_d = 1'b0;

        push_d  = accept;
        pdata_d = accept ? imem_rdata_i : pdata_q;
        paddr_d = accept ? pc_q : paddr_q;
        flush_d = redirect_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_PC;
            addr_q  <= BOOT_PC;
            cred_q  <= CRED_MAX;
            kill_q  <= 1'b0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            paddr_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cred_q  <= cred_d;
            kill_q  <= kill_d;
            push_q  <= push_d;
            pdata_q <= pdata_d;
            paddr_q <= paddr_d;
            flush_q <= flush_d;
        end
    end

    assign imem_req_o  = (state_q == S_WRDY);
    assign imem_addr_o = addr_q;
    assign busy_o      = (state_q != S_IDLE);
    assign pf_push_o   = push_q;
    assign pf_data_o   = pdata_q;
    assign pf_addr_o   = paddr_q;
    assign pf_flush_o  = flush_q;

endmodule

// File: tb/tb_ristretto_imem_fetch_ctrl.sv
// Bench for ristretto_imem_fetch_ctrl: transaction-level memory/buffer model with
// directed scenarios followed by a randomized phase.
module tb_ristretto_imem_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam logic [31:0] BOOT = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0, redir = 1'b0, rdy = 1'b0, rvalid = 1'b0, pop = 1'b0;
    logic [31:0] raddr = '0, rdata = '0;
    logic        imem_req_o, pf_push_o, pf_flush_o, busy_o;
    logic [31:0] imem_addr_o, pf_data_o, pf_addr_o;

    ristretto_imem_fetch_ctrl #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en), .redirect_i(redir),
        .redirect_addr_i(raddr), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rdy_i(rdy), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .pf_push_o(pf_push_o), .pf_data_o(pf_data_o), .pf_addr_o(pf_addr_o),
        .pf_pop_i(pop), .pf_flush_o(pf_flush_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0, cyc = 0;
    int rdy_pct = 100, rv_pct = 100, pop_pct = 0, redir_pct = 0, spur_pct = 0;
    bit redir_now = 0, pop_now = 0, rv_now = 0;
    logic [31:0] redir_to = '0;

    // Reference model state: one outstanding transaction, buffer occupancy, credits.
    bit          outstanding = 0, txn_killed = 0;
    logic [31:0] acc_addr = '0, next_fetch = BOOT;
    int          cred = DEPTH, occ = 0;
    logic [31:0] push_log[$], acc_log[$];
    int          push_cyc[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        push_log.delete(); acc_log.delete(); push_cyc.delete();
    endtask

    task automatic tick();
        bit s_req, s_out, rv_real, rkill, newreq, pe, exp_req, exp_push;
        logic [31:0] s_addr, rsp_addr;
        int cred0;
        s_req = imem_req_o; s_addr = imem_addr_o; s_out = outstanding;
        rdy     = s_req && ($urandom_range(99) < rdy_pct);
        rv_real = s_out && (rv_now || $urandom_range(99) < rv_pct);
        rvalid  = rv_real || (!s_out && $urandom_range(99) < spur_pct);
        rdata   = rv_real ? mem_word(acc_addr) : $urandom;
        redir   = redir_now || ($urandom_range(99) < redir_pct);
        raddr   = redir_now ? redir_to : $urandom;
        pop     = pop_now || ((occ - int'(pf_push_o)) > 0 && $urandom_range(99) < pop_pct);
        if (redir && (s_req || s_out)) txn_killed = 1;
        rkill    = txn_killed || (rv_real && redir);
        rsp_addr = acc_addr;
        if (s_req && rdy) begin
            outstanding = 1; acc_addr = s_addr; acc_log.push_back(s_addr);
        end
        if (rv_real) outstanding = 0;

        @(posedge clk); #1; cyc++;

        exp_push = rv_real && !rkill;
        chk("push", pf_push_o, exp_push);
        if (exp_push) begin
            chk("pf_addr", pf_addr_o, rsp_addr);
            chk("pf_data", pf_data_o, mem_word(rsp_addr));
            occ++;
            chk("overflow", occ <= DEPTH, 1);
            push_log.push_back(rsp_addr); push_cyc.push_back(cyc);
        end
        chk("flush", pf_flush_o, redir);
        if (redir) occ = 0;
        else if (pop && occ > 0) occ--;

        cred0   = cred;
        newreq  = imem_req_o && !s_req;
        exp_req = (s_req && !rdy) ||
                  (((!s_req && !s_out) || rv_real) && fetch_en && cred0 > 0 && !redir);
        chk("req", imem_req_o, exp_req);
        pe = pop && !redir && cred0 < DEPTH;
        if (redir) begin
            cred = DEPTH; next_fetch = {raddr[31:2], 2'b00};
        end else cred = cred0 + int'(pe) - int'(newreq);
        if (newreq) begin
            chk("req_addr", imem_addr_o, next_fetch);
            next_fetch += 32'd4; txn_killed = 0;
        end else if (imem_req_o) chk("addr_hold", imem_addr_o, s_addr);
        chk("busy", busy_o, imem_req_o || outstanding);
        redir_now = 0; pop_now = 0; rv_now = 0;
    endtask

    task automatic do_reset();
        rst = 1; fetch_en = 0; redir = 0; rdy = 0; rvalid = 0; pop = 0; rdata = '0; raddr = '0;
        @(posedge clk); #1;
        rst = 0;
        outstanding = 0; txn_killed = 0; cred = DEPTH; occ = 0; next_fetch = BOOT;
        chk("rst_req", imem_req_o, 0);
        chk("rst_push", pf_push_o, 0);
        chk("rst_flush", pf_flush_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pdata", pf_data_o, 0);
        chk("rst_paddr", pf_addr_o, 0);
        chk("rst_pc", imem_addr_o, BOOT);
    endtask

    task automatic wait_outstanding(string tag);
        for (int i = 0; i < 10 && !outstanding; i++) tick();
        chk(tag, outstanding, 1);
    endtask

    initial begin
        do_reset();

        // Streaming with zero wait states until credits run out.
        clear_logs(); fetch_en = 1;
        repeat (14) tick();
        chk("stream_n", push_log.size(), 4);
        for (int i = 0; i < push_log.size(); i++)
            chk("stream_addr", push_log[i], BOOT + 32'(4 * i));
        for (int i = 1; i < push_cyc.size(); i++)
            chk("stream_gap", push_cyc[i] - push_cyc[i-1], 2);
        chk("stall_req", imem_req_o, 0);

        // One pop releases exactly one more fetch.
        clear_logs(); pop_now = 1; tick(); tick();
        chk("resume_req", imem_req_o, 1);
        chk("resume_addr", imem_addr_o, 32'h110);
        repeat (8) tick();
        chk("resume_n", push_log.size(), 1);
        if (push_log.size() > 0) chk("resume_push", push_log[0], 32'h110);

        // Wait states with a redirect while the request is pending.
        fetch_en = 0; redir_now = 1; redir_to = 32'h300; tick();
        fetch_en = 1; rdy_pct = 0; tick();
        repeat (3) tick();
        redir_now = 1; redir_to = 32'h2000; tick();
        chk("ws_req", imem_req_o, 1);
        chk("ws_addr", imem_addr_o, 32'h300);
        clear_logs(); rdy_pct = 100;
        repeat (8) tick();
        chk("ws_acc_n", acc_log.size() >= 2, 1);
        if (acc_log.size() >= 2) begin
            chk("ws_acc_old", acc_log[0], 32'h300);
            chk("ws_acc_new", acc_log[1], 32'h2000);
        end
        chk("ws_push_n", push_log.size() > 0, 1);
        if (push_log.size() > 0) chk("ws_first_push", push_log[0], 32'h2000);

        // Redirect in the same cycle as rvalid.
        rv_pct = 0; redir_now = 1; redir_to = 32'h500; tick();
        wait_outstanding("rr_timeout");
        clear_logs(); redir_now = 1; redir_to = 32'h400; rv_now = 1; tick();
        chk("rr_push", pf_push_o, 0);
        chk("rr_flush", pf_flush_o, 1);
        rv_pct = 100;
        repeat (12) tick();
        chk("rr_credits_n", push_log.size(), DEPTH);
        if (push_log.size() > 0) chk("rr_first", push_log[0], 32'h400);

        // PC wrap.
        clear_logs(); redir_now = 1; redir_to = 32'hFFFF_FFFC; tick();
        repeat (12) tick();
        chk("wrap_n", push_log.size() >= 2, 1);
        if (push_log.size() >= 2) begin
            chk("wrap_0", push_log[0], 32'hFFFF_FFFC);
            chk("wrap_1", push_log[1], 32'h0);
        end

        // Reset while waiting for rvalid, then a late rvalid.
        rv_pct = 0; redir_now = 1; redir_to = 32'h600; tick();
        wait_outstanding("rst_wvld_timeout");
        tick();
        do_reset();
        spur_pct = 100; tick(); spur_pct = 0;
        chk("late_push", pf_push_o, 0);
        chk("late_busy", busy_o, 0);
        chk("late_pc", imem_addr_o, BOOT);

        // Randomized traffic against the model.
        rdy_pct = 60; rv_pct = 60; pop_pct = 40; redir_pct = 3; spur_pct = 5;
        for (int i = 0; i < 1500; i++) begin
            fetch_en = ($urandom_range(99) < 85);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
